// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use stall, hold and flush
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_uses_rt,
  input  logic          id_alu_src,
  input  logic [3:0]    id_alu_control,
  input  logic [4:0]    id_shamt,
  input  logic [2:0]    id_branch_type,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_reg_write,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_alu_out,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_alu_control,
  output logic [4:0]    ex_shamt,
  output logic [2:0]    ex_branch_type,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_reg_write,
  output logic          ex_valid,
  output logic          load_use_stall
);
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          uses_rt;
    logic          alu_src;
    logic [3:0]    alu_control;
    logic [4:0]    shamt;
    logic [2:0]    branch_type;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
  } stage_t;

  stage_t        stage_q, stage_d, id_s, held_s;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // Forward from the youngest in-flight producer; register 0 is hardwired and never forwarded
  always_comb begin
    fwd_rs = (exmem_reg_write && exmem_rd != '0 && exmem_rd == stage_q.rs) ? exmem_alu_out :
             (memwb_reg_write && memwb_rd != '0 && memwb_rd == stage_q.rs) ? memwb_result : stage_q.rs_data;
    fwd_rt = (exmem_reg_write && exmem_rd != '0 && exmem_rd == stage_q.rt) ? exmem_alu_out :
             (memwb_reg_write && memwb_rd != '0 && memwb_rd == stage_q.rt) ? memwb_result : stage_q.rt_data;
  end

  assign load_use_stall = id_valid && stage_q.valid && stage_q.mem_read && stage_q.rd != '0 &&
                          (stage_q.rd == id_rs || (id_uses_rt && stage_q.rd == id_rt));

  // Next-state select: flush > hold > load-use bubble > capture; held data absorbs retiring producers
  always_comb begin
    id_s             = '0;
    id_s.valid       = 1'b1;
    id_s.rs_data     = id_rs_data;
    id_s.rt_data     = id_rt_data;
    id_s.imm         = id_imm;
    id_s.rs          = id_rs;
    id_s.rt          = id_rt;
    id_s.rd          = id_rd;
    id_s.uses_rt     = id_uses_rt;
    id_s.alu_src     = id_alu_src;
    id_s.alu_control = id_alu_control;
    id_s.shamt       = id_shamt;
    id_s.branch_type = id_branch_type;
    id_s.mem_read    = id_mem_read;
    id_s.mem_write   = id_mem_write;
    id_s.reg_write   = id_reg_write;
    held_s           = stage_q;
    held_s.rs_data   = fwd_rs;
    held_s.rt_data   = fwd_rt;
    stage_d          = flush ? '0 : hold ? held_s : (load_use_stall || !id_valid) ? '0 : id_s;
  end

  // Pipeline register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign ex_a           = fwd_rs;
  assign ex_b           = stage_q.alu_src ? stage_q.imm : fwd_rt;
  assign ex_store_data  = fwd_rt;
  assign ex_alu_control = stage_q.alu_control;
  assign ex_shamt       = stage_q.shamt;
  assign ex_branch_type = stage_q.branch_type;
  assign ex_rd          = stage_q.rd;
  assign ex_mem_read    = stage_q.mem_read;
  assign ex_mem_write   = stage_q.mem_write;
  assign ex_reg_write   = stage_q.reg_write;
  assign ex_valid       = stage_q.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed per-feature checks of the ID/EX stage
module tb_id_ex_stage;
  logic        clk = 1'b0, rst = 1'b1, hold = 1'b0, flush = 1'b0;
  logic        id_valid = 1'b0, id_uses_rt = 1'b0, id_alu_src = 1'b0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
  logic [3:0]  id_alu_control = '0;
  logic [2:0]  id_branch_type = '0;
  logic        id_mem_read = 1'b0, id_mem_write = 1'b0, id_reg_write = 1'b0;
  logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_alu_out = '0, memwb_result = '0;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_shamt, ex_rd;
  logic [2:0]  ex_branch_type;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_valid, load_use_stall;
  int          n_cmp = 0, n_bad = 0;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control), .id_shamt(id_shamt),
    .id_branch_type(id_branch_type), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_alu_out(exmem_alu_out), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control),
    .ex_shamt(ex_shamt), .ex_branch_type(ex_branch_type), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_valid(ex_valid), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic urt, input logic asrc, input logic [3:0] ac, input logic [2:0] bt,
                          input logic mr, input logic mw, input logic rw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_uses_rt = urt; id_alu_src = asrc; id_alu_control = ac; id_branch_type = bt;
    id_mem_read = mr; id_mem_write = mw; id_reg_write = rw; id_shamt = 5'd13;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_init_valid: got %b exp 0", ex_valid); end
    rst = 1'b0;
    step();
    drive_id(1, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h0, 1, 0, 4'h5, 3'd2, 0, 1, 0);
    step();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL reset_pre_valid: got %b exp 1", ex_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_async_valid: got %b exp 0", ex_valid); end
    n_cmp++; if (ex_a !== 32'h0) begin n_bad++; $display("FAIL reset_async_a: got %h exp 0", ex_a); end
    n_cmp++; if (ex_alu_control !== 4'h0 || ex_branch_type !== 3'd0 || ex_mem_write !== 1'b0 || ex_rd !== 5'd0)
      begin n_bad++; $display("FAIL reset_async_ctl: got ac=%h bt=%h mw=%b rd=%h exp all 0", ex_alu_control, ex_branch_type, ex_mem_write, ex_rd); end
    rst = 1'b0;
    drive_id(1, 5'd4, 5'd6, 5'd7, 32'h44, 32'h66, 32'h0, 1, 0, 4'h3, 3'd0, 0, 0, 1);
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_alu_control !== 4'h3 || ex_shamt !== 5'd13)
      begin n_bad++; $display("FAIL reset_first_capture: got v=%b rd=%h ac=%h sh=%h exp v=1 rd=7 ac=3 sh=d", ex_valid, ex_rd, ex_alu_control, ex_shamt); end
    n_cmp++; if (ex_a !== 32'h44 || ex_b !== 32'h66)
      begin n_bad++; $display("FAIL reset_first_ops: got a=%h b=%h exp a=44 b=66", ex_a, ex_b); end
  endtask

  task automatic test_forward();
    drive_id(1, 5'd5, 5'd6, 5'd2, 32'h55, 32'h66, 32'h0, 1, 0, 4'h1, 3'd0, 0, 0, 1);
    step();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_alu_out = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
    #1;
    n_cmp++; if (ex_a !== 32'h11) begin n_bad++; $display("FAIL fwd_exmem_wins: got %h exp 11", ex_a); end
    exmem_reg_write = 0;
    #1;
    n_cmp++; if (ex_a !== 32'h22) begin n_bad++; $display("FAIL fwd_memwb: got %h exp 22", ex_a); end
    exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    n_cmp++; if (ex_a !== 32'h55) begin n_bad++; $display("FAIL fwd_rd_zero: got %h exp 55", ex_a); end
    memwb_rd = 5'd6;
    #1;
    n_cmp++; if (ex_b !== 32'h22 || ex_store_data !== 32'h22)
      begin n_bad++; $display("FAIL fwd_rt: got b=%h sd=%h exp 22", ex_b, ex_store_data); end
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
  endtask

  task automatic test_imm_select();
    drive_id(1, 5'd1, 5'd3, 5'd4, 32'h1, 32'h7, 32'hFFFF_FFF0, 0, 1, 4'h2, 3'd0, 0, 0, 1);
    step();
    n_cmp++; if (ex_b !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL imm_b: got %h exp fffffff0", ex_b); end
    n_cmp++; if (ex_store_data !== 32'h7) begin n_bad++; $display("FAIL imm_store: got %h exp 7", ex_store_data); end
  endtask

  task automatic test_load_use();
    drive_id(1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h4, 0, 1, 4'h0, 3'd0, 1, 0, 1);
    step();
    drive_id(1, 5'd8, 5'd3, 5'd10, 32'h0, 32'h0, 32'h0, 1, 0, 4'h2, 3'd0, 0, 0, 1);
    #1;
    n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_detect: got %b exp 1", load_use_stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0)
      begin n_bad++; $display("FAIL lu_bubble: got v=%b rw=%b exp 0 0", ex_valid, ex_reg_write); end
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_one_cycle: got %b exp 0", load_use_stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_alu_control !== 4'h2)
      begin n_bad++; $display("FAIL lu_capture: got v=%b rd=%h ac=%h exp 1 a 2", ex_valid, ex_rd, ex_alu_control); end
    drive_id(1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h4, 0, 1, 4'h0, 3'd0, 1, 0, 1);
    step();
    drive_id(1, 5'd1, 5'd8, 5'd11, 32'h0, 32'h0, 32'h0, 0, 1, 4'h2, 3'd0, 0, 0, 1);
    #1;
    n_cmp++; if (load_use_stall !== 1'b0) begin n_bad++; $display("FAIL lu_rt_unused: got %b exp 0", load_use_stall); end
    id_uses_rt = 1;
    #1;
    n_cmp++; if (load_use_stall !== 1'b1) begin n_bad++; $display("FAIL lu_rt_used: got %b exp 1", load_use_stall); end
    id_valid = 0;
    step();
  endtask

  task automatic test_hold_refresh();
    drive_id(1, 5'd9, 5'd2, 5'd12, 32'h99, 32'h0, 32'h0, 1, 0, 4'h1, 3'd0, 0, 0, 1);
    step();
    hold = 1; drive_id(1, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h0, 1, 0, 4'h7, 3'd1, 0, 0, 1);
    memwb_reg_write = 1; memwb_rd = 5'd9; memwb_result = 32'hABCD;
    #1;
    n_cmp++; if (ex_a !== 32'hABCD) begin n_bad++; $display("FAIL hold_c1: got %h exp abcd", ex_a); end
    step();
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    #1;
    n_cmp++; if (ex_a !== 32'hABCD) begin n_bad++; $display("FAIL hold_c2: got %h exp abcd", ex_a); end
    step();
    n_cmp++; if (ex_a !== 32'hABCD || ex_rd !== 5'd12 || ex_alu_control !== 4'h1)
      begin n_bad++; $display("FAIL hold_c3: got a=%h rd=%h ac=%h exp abcd c 1", ex_a, ex_rd, ex_alu_control); end
    hold = 0;
    #1;
    n_cmp++; if (ex_a !== 32'hABCD) begin n_bad++; $display("FAIL hold_drop: got %h exp abcd", ex_a); end
    step();
    n_cmp++; if (ex_rd !== 5'd5 || ex_branch_type !== 3'd1)
      begin n_bad++; $display("FAIL hold_resume: got rd=%h bt=%h exp 5 1", ex_rd, ex_branch_type); end
  endtask

  task automatic test_flush_hold();
    drive_id(1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 1, 0, 4'h9, 3'd3, 0, 1, 0);
    step();
    n_cmp++; if (ex_branch_type !== 3'd3 || ex_mem_write !== 1'b1)
      begin n_bad++; $display("FAIL flush_pre: got bt=%h mw=%b exp 3 1", ex_branch_type, ex_mem_write); end
    hold = 1; flush = 1;
    step();
    n_cmp++; if (ex_valid !== 1'b0 || ex_branch_type !== 3'd0 || ex_mem_write !== 1'b0 || ex_alu_control !== 4'h0)
      begin n_bad++; $display("FAIL flush_hold: got v=%b bt=%h mw=%b ac=%h exp 0", ex_valid, ex_branch_type, ex_mem_write, ex_alu_control); end
    hold = 0; flush = 0;
  endtask

  task automatic test_hold_load_use();
    drive_id(1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'h4, 0, 1, 4'h0, 3'd0, 1, 0, 1);
    step();
    drive_id(1, 5'd8, 5'd3, 5'd10, 32'h0, 32'h0, 32'h0, 1, 0, 4'h2, 3'd0, 0, 0, 1);
    hold = 1;
    step();
    step();
    n_cmp++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd8 || load_use_stall !== 1'b1)
      begin n_bad++; $display("FAIL hold_lu_keep: got mr=%b rd=%h st=%b exp 1 8 1", ex_mem_read, ex_rd, load_use_stall); end
    hold = 0;
    step();
    n_cmp++; if (ex_valid !== 1'b0 || load_use_stall !== 1'b0)
      begin n_bad++; $display("FAIL hold_lu_release: got v=%b st=%b exp 0 0", ex_valid, load_use_stall); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_imm_select();
    test_load_use();
    test_hold_refresh();
    test_flush_hold();
    test_hold_load_use();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the EX-stage ALU.
- Latches decoded instruction fields from ID and drives ALU operands A/B, ALU control, shift amount and branch type.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles; supports downstream hold and branch flush.

Parameters:
- DW, 32, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hold  in  1  downstream stall; freeze stage contents
- flush  in  1  branch taken; kill stage contents
- id_valid  in  1  ID holds a real instruction
- id_rs_data  in  DW  register-file read port 1
- id_rt_data  in  DW  register-file read port 2
- id_imm  in  DW  extended immediate
- id_rs  in  RW  source index 1
- id_rt  in  RW  source index 2
- id_rd  in  RW  destination index
- id_uses_rt  in  1  instruction reads rt
- id_alu_src  in  1  1 = B takes immediate
- id_alu_control  in  4  ALU opcode
- id_shamt  in  5  shift amount
- id_branch_type  in  3  branch code
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- id_reg_write  in  1  writes rd
- exmem_reg_write  in  1  EX/MEM writeback enable
- exmem_rd  in  RW  EX/MEM destination
- exmem_alu_out  in  DW  EX/MEM result
- memwb_reg_write  in  1  MEM/WB writeback enable
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB result
- ex_a  out  DW  ALU operand A
- ex_b  out  DW  ALU operand B
- ex_alu_control  out  4  to ALU
- ex_shamt  out  5  to ALU
- ex_branch_type  out  3  to ALU
- ex_store_data  out  DW  forwarded rt for stores
- ex_rd  out  RW  registered destination
- ex_mem_read  out  1  registered
- ex_mem_write  out  1  registered
- ex_reg_write  out  1  registered
- ex_valid  out  1  EX holds a real instruction
- load_use_stall  out  1  hold IF/ID this cycle

Behaviour:
- Reset (async, rst=1): all registered fields clear to 0. ex_valid=0; ex_alu_control=0; ex_branch_type=0; all control bits 0. Outputs settle to 0 immediately, without waiting for a clock edge.
- Registered state: valid, rs/rt data, imm, rs/rt/rd indices, uses_rt, alu_src, alu_control, shamt, branch_type, mem_read, mem_write, reg_write.
- Per-edge update priority:
  - flush > hold > load_use_stall > normal load.
  - flush: load a bubble (valid=0, every control field 0, data don't-care and set to 0).
  - hold (no flush): keep all fields. Exception: held rs/rt data are refreshed with the currently forwarded value (see Forwarding), so a producer retiring during the hold is not lost.
  - load_use_stall (no hold/flush): load a bubble.
  - normal: capture all id_* fields. When id_valid=0, capture as bubble.
- A bubble never writes, never branches (branch_type=0), and has alu_control=0.
- Forwarding (combinational, from registered indices):
  - fwd_rs = registered rs_data by default.
  - If exmem_reg_write and exmem_rd!=0 and exmem_rd==rs: exmem_alu_out.
  - Else if memwb_reg_write and memwb_rd!=0 and memwb_rd==rs: memwb_result.
  - fwd_rt: identical rule on rt.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Operand outputs:
  - ex_a = fwd_rs.
  - ex_b = alu_src ? imm : fwd_rt.
  - ex_store_data = fwd_rt.
  - All other ex_* outputs are straight register outputs.
  - Latency: one cycle from id_* to ex_*.
- Load-use detection (combinational):
  - load_use_stall = id_valid & valid & mem_read & rd!=0 & (rd==id_rs | (id_uses_rt & rd==id_rt)).
  - The bubble inserted on the next edge clears the condition, giving exactly one stall cycle per load-use pair.
- Simultaneous events: flush with load_use_stall yields a bubble; load_use_stall stays asserted that cycle, which is harmless because upstream is flushed too. hold with load_use_stall keeps the load in EX; the stall persists until hold drops.
- No arithmetic in this block; all widths are pass-through.

Test Plan:
- Reset: rst=1 mid-operation with ex_valid=1 → all outputs 0 before the next clk edge; after release, first valid id_* appears on ex_* one edge later.
- Forward priority: EX instr rs=5; exmem_rd=5, exmem_alu_out=0x11, memwb_rd=5, memwb_result=0x22, both write-enables 1 → ex_a=0x11. Set exmem_reg_write=0 → ex_a=0x22. Set both rd=0 → ex_a=registered rs_data.
- Immediate select: id_alu_src=1, id_imm=0xFFFF_FFF0, id_rt_data=0x7 → ex_b=0xFFFF_FFF0, ex_store_data=0x7.
- Load-use: EX lw with rd=8; ID add with rs=8, id_valid=1 → load_use_stall=1 for exactly one cycle; next ex_valid=0, ex_reg_write=0; following edge captures the add.
- Hold refresh: hold=1 for 3 cycles with EX rs=9; memwb_rd=9, memwb_result=0xABCD in cycle 1 only → ex_a stays 0xABCD in cycles 2–3 and after hold drops.
- Flush vs hold: flush=1 and hold=1 on the same edge → ex_valid=0, ex_branch_type=0, ex_mem_write=0 after that edge.
